// File: rtl/serial_seq_controller.sv
// Drives one MSB-first bit sequence into a serial Mealy detector and counts
// the cycles in which the detector reports a hit.
module serial_seq_controller #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] len,
  input  logic             det_in,
  output logic             x_out,
  output logic             det_clr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   hit_q, hit_d;
  logic [CNT_W-1:0]   len_clamped;

  // Out-of-range lengths run the whole pattern rather than wrapping.
  assign len_clamped = (int'(len) > PAT_W) ? CNT_W'(PAT_W) : len;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rem_d   = rem_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = pattern;
          rem_d   = len_clamped;
          hit_d   = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        state_d = (rem_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
        rem_d   = rem_q - CNT_W'(1);
        if (det_in) hit_d = hit_q + CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      rem_q   <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      hit_q   <= hit_d;
    end
  end

  // Outputs depend only on registered state so det_in never loops back
  // combinationally into the detector.
  assign x_out     = (state_q == SHIFT) & shreg_q[PAT_W-1];
  assign det_clr   = (state_q == CLEAR);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign hit_count = hit_q;

endmodule

// File: tb/tb_serial_seq_controller.sv
// Cycle-exact scoreboard bench: every driven cycle pushes the outputs that
// cycle must show; a negedge monitor pops and compares them.
module tb_serial_seq_controller;
  localparam int PAT_W = 8;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset, start, det_in;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] len;
  logic             x_out, det_clr, busy, done;
  logic [CNT_W-1:0] hit_count;

  typedef struct packed {
    logic             x;
    logic             clr;
    logic             bsy;
    logic             dn;
    logic [CNT_W-1:0] hit;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  serial_seq_controller #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .det_in(det_in), .x_out(x_out), .det_clr(det_clr), .busy(busy),
    .done(done), .hit_count(hit_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("outs{x,clr,busy,done,hit}",
          32'({x_out, det_clr, busy, done, hit_count}), 32'(e));
    end
  end

  // Drive one cycle's inputs and push the outputs expected in that cycle.
  task automatic cyc(input logic st, input logic rs, input logic di, input exp_t e);
    start  = st;
    reset  = rs;
    det_in = di;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  function automatic exp_t idle_e(input logic [CNT_W-1:0] h);
    return '{x: 1'b0, clr: 1'b0, bsy: 1'b0, dn: 1'b0, hit: h};
  endfunction

  // One run: start cycle in IDLE, CLEAR, len SHIFT cycles, DONE, then an
  // IDLE cycle unless hold keeps start high for a back-to-back run.
  task automatic run(input logic [PAT_W-1:0] pat, input int ln, input logic [PAT_W-1:0] dmask,
                     input logic [CNT_W-1:0] hprev, input bit hold, output logic [CNT_W-1:0] hfin);
    int L;
    logic [CNT_W-1:0] h;
    L = (ln > PAT_W) ? PAT_W : ln;
    h = '0;
    pattern = pat;
    len     = CNT_W'(ln);
    cyc(1'b1, 1'b0, 1'b0, idle_e(hprev));
    pattern = ~pat;
    len     = CNT_W'($urandom_range(0, 15));
    cyc(1'b0, 1'b0, 1'b0, '{x: 1'b0, clr: 1'b1, bsy: 1'b1, dn: 1'b0, hit: '0});
    for (int i = 0; i < L; i++) begin
      cyc(hold && i >= 2, 1'b0, dmask[i],
          '{x: pat[PAT_W-1-i], clr: 1'b0, bsy: 1'b1, dn: 1'b0, hit: h});
      if (dmask[i]) h = h + 1'b1;
    end
    cyc(hold, 1'b0, 1'b0, '{x: 1'b0, clr: 1'b0, bsy: 1'b1, dn: 1'b1, hit: h});
    if (!hold) cyc(1'b0, 1'b0, 1'b0, idle_e(h));
    hfin = h;
  endtask

  initial begin
    logic [CNT_W-1:0] h;
    reset = 1'b1; start = 1'b0; det_in = 1'b0; pattern = '0; len = '0;
    @(posedge clock);
    #1;
    cyc(1'b0, 1'b1, 1'b0, idle_e('0));
    // Reset wins over start in the same cycle.
    cyc(1'b1, 1'b1, 1'b0, idle_e('0));
    cyc(1'b0, 1'b0, 1'b0, idle_e('0));

    run(8'hB4, 8, 8'h00, '0, 1'b0, h);
    run(8'hB4, 8, 8'h2C, h, 1'b0, h);
    cyc(1'b0, 1'b0, 1'b0, idle_e(4'd3));
    run(8'hFF, 3, 8'h00, 4'd3, 1'b0, h);
    run(8'hA5, 0, 8'hFF, '0, 1'b0, h);
    run(8'h6D, 12, 8'hC3, '0, 1'b0, h);   // clamped to 8, expects hit 4
    chk("clamp_hits", 32'(h), 32'd4);

    // Reset in the 4th SHIFT cycle aborts the run with no done pulse.
    pattern = 8'hB4; len = 4'd8;
    cyc(1'b1, 1'b0, 1'b0, idle_e(h));
    cyc(1'b0, 1'b0, 1'b0, '{x: 1'b0, clr: 1'b1, bsy: 1'b1, dn: 1'b0, hit: '0});
    cyc(1'b0, 1'b0, 1'b1, '{x: 1'b1, clr: 1'b0, bsy: 1'b1, dn: 1'b0, hit: 4'd0});
    cyc(1'b0, 1'b0, 1'b1, '{x: 1'b0, clr: 1'b0, bsy: 1'b1, dn: 1'b0, hit: 4'd1});
    cyc(1'b0, 1'b0, 1'b0, '{x: 1'b1, clr: 1'b0, bsy: 1'b1, dn: 1'b0, hit: 4'd2});
    cyc(1'b0, 1'b1, 1'b1, '{x: 1'b1, clr: 1'b0, bsy: 1'b1, dn: 1'b0, hit: 4'd2});
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, idle_e('0));
    run(8'h81, 2, 8'h01, '0, 1'b0, h);

    // start raised mid-SHIFT and held through DONE: second run back-to-back.
    run(8'h3C, 5, 8'h12, h, 1'b1, h);
    run(8'hE7, 4, 8'h0F, h, 1'b0, h);

    @(negedge clock);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/serial_seq_controller.md
SERIAL_SEQ_CONTROLLER -- requirements
Module: serial_seq_controller

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high (ports `clock`, `reset`).
REQ-002 Parameters (name, default, meaning), one per line:
- PAT_W, 8, pattern register width in bits.
- CNT_W, 4, width of the bit counter and the hit counter.
REQ-003 Ports (name direction width meaning), one per line:
- clock input 1 system clock, rising edge.
- reset input 1 synchronous active-high reset.
- start input 1 request to run one sequence; sampled only in IDLE.
- pattern input PAT_W bits to send, MSB first; captured on start acceptance.
- len input CNT_W number of bits to send, valid range 0..PAT_W.
- det_in input 1 y_out of the serial Mealy detector under control.
- x_out output 1 serial bit driven to the detector's x_in.
- det_clr output 1 one-cycle active-high clear pulse to the detector.
- busy output 1 high in every state except IDLE.
- done output 1 one-cycle completion pulse.
- hit_count output CNT_W number of SHIFT cycles with det_in=1 in the last run.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, CLEAR, SHIFT, DONE.
REQ-005 IDLE, start=1 at a rising edge: capture pattern into shreg and len into remaining, clear hit_count to 0, next state CLEAR.
REQ-006 IDLE, start=0: the FSM SHALL remain in IDLE with all registers held.
REQ-007 CLEAR lasts exactly 1 cycle: det_clr=1 and x_out=0.
REQ-008 CLEAR exit: next state SHIFT if remaining is nonzero; otherwise DONE (len=0 case).
REQ-009 SHIFT, each cycle:
- x_out = shreg[PAT_W-1].
- At the edge, shreg shifts left by one with 0 filled in, and remaining decrements by 1.
REQ-010 SHIFT, each cycle: if det_in=1, hit_count increments by 1 at the edge; det_in is sampled in the same cycle as the x_out bit that produced it (Mealy, zero latency).
REQ-011 SHIFT exit: when remaining=1 at an edge, next state DONE; SHIFT therefore lasts exactly len cycles.
REQ-012 DONE lasts exactly 1 cycle with done=1, x_out=0; next state IDLE.
REQ-013 Latency: done SHALL be high in the cycle len+2 cycles after the edge that accepted start.
REQ-014 start SHALL be ignored in CLEAR, SHIFT and DONE; start held high in DONE is accepted only on the first IDLE edge, one cycle after DONE.
REQ-015 pattern and len changes while busy=1 SHALL have no effect on the current run.
REQ-016 len greater than PAT_W is out of range; the block SHALL clamp it to PAT_W on capture.
REQ-017 hit_count SHALL hold its final value from DONE until the next accepted start; its maximum value is PAT_W, so no overflow is possible with the default CNT_W.
REQ-018 Outputs SHALL be registered or decoded from the state register only; det_in SHALL NOT combinationally reach any output.

Reset
REQ-019 With reset=1 at a rising edge, the following SHALL apply regardless of state, including mid-SHIFT:
- state=IDLE.
- x_out=0, det_clr=0, busy=0, done=0.
- hit_count=0, shreg=0, remaining=0.
REQ-020 The reset edge SHALL take priority over start in the same cycle; no run is started.
REQ-021 An interrupted run SHALL produce no done pulse.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- pattern=8'hB4, len=8, det_in=0: x_out sequence in SHIFT is 1,0,1,1,0,1,0,0; done high 10 cycles after the start edge; hit_count=0.
- pattern=8'hB4, len=8, det_in=1 in the 3rd, 4th and 6th SHIFT cycles: hit_count=3 at DONE, held in IDLE.
- pattern=8'hFF, len=3: exactly 3 SHIFT cycles with x_out=1; det_clr high exactly 1 cycle before them; done 5 cycles after start.
- len=0: sequence CLEAR then DONE; done 2 cycles after start; x_out stays 0; hit_count=0.
- reset=1 in the 4th SHIFT cycle: next cycle busy=0, hit_count=0, x_out=0; no done pulse; a new start runs normally.
- start pulsed during SHIFT and held high through DONE: the first run is unaffected; a second run begins at the first IDLE edge, with det_clr seen one cycle later.
